// File: rtl/rptr_empty.sv
// Read-side pointer and empty/almost-empty/level logic for an async FIFO.
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_EN.
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_ptr;
  logic              r_empty;
  logic              r_aempty;
  logic [ADDRSIZE:0] r_level;

  logic              w_pop;
  logic [ADDRSIZE:0] w_binnext;
  logic [ADDRSIZE:0] w_graynext;
  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_levelnext;

  assign w_pop      = rinc & ~r_empty;
  assign w_binnext  = r_bin + {{ADDRSIZE{1'b0}}, w_pop};
  assign w_graynext = (w_binnext >> 1) ^ w_binnext;

  // Gray to binary: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign w_levelnext = w_wbin - w_binnext;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_bin    <= '0;
      r_ptr    <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_level  <= '0;
    end else begin
      r_bin    <= w_binnext;
      r_ptr    <= w_graynext;
      r_empty  <= (w_graynext == rq2_wptr);
      r_aempty <= (w_levelnext <= (ADDRSIZE+1)'(AEMPTY_THRESH));
      r_level  <= w_levelnext;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic r_underflow;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_underflow <= 1'b0;
    end else if (rinc && r_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign runderflow = r_underflow;
`else
  assign runderflow = 1'b0;
`endif

  assign raddr   = r_bin[ADDRSIZE-1:0];
  assign rptr    = r_ptr;
  assign rempty  = r_empty;
  assign raempty = r_aempty;
  assign rlevel  = r_level;

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty: a count-based read model predicts
// every registered output; a monitor compares one cycle later.
module tb_rptr_empty;

  localparam int A  = 4;
  localparam int TH = 2;
  localparam int M  = 1 << (A + 1);
  localparam int D  = 1 << A;

  typedef struct {
    logic [A:0]   rptr;
    logic [A-1:0] raddr;
    logic         empty;
    logic         aempty;
    logic [A:0]   level;
    logic         uf;
  } exp_t;

  logic         rclk = 1'b0;
  logic         rrst_n = 1'b0;
  logic         rinc = 1'b0;
  logic [A:0]   rq2_wptr = '0;
  logic [A-1:0] raddr;
  logic [A:0]   rptr;
  logic         rempty;
  logic         raempty;
  logic [A:0]   rlevel;
  logic         runderflow;

  rptr_empty #(.ADDRSIZE(A), .AEMPTY_THRESH(TH)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rinc       (rinc),
    .rq2_wptr   (rq2_wptr),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  always #5 rclk = ~rclk;

  int   checks = 0;
  int   errors = 0;
  int   wcnt = 0;
  int   m_rd = 0;
  bit   m_empty = 1'b1;
  bit   m_uf = 1'b0;
  exp_t q[$];

  function automatic logic [A:0] gray(input int v);
    logic [A:0] b;
    b = (A+1)'(((v % M) + M) % M);
    return b ^ (b >> 1);
  endfunction

  function automatic void chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", n, got, exp, $time);
    end
  endfunction

  // One cycle of stimulus; the model predicts state after the next edge
  task automatic step(input bit rst_n, input bit inc);
    int   lvl;
    exp_t e;
    @(negedge rclk);
    rrst_n   = rst_n;
    rinc     = inc;
    rq2_wptr = gray(wcnt);
    if (!rst_n) begin
      m_rd    = 0;
      m_empty = 1'b1;
      m_uf    = 1'b0;
      lvl     = 0;
    end else begin
`ifdef RPTR_UNDERFLOW_EN
      if (inc && m_empty) m_uf = 1'b1;
`endif
      if (inc && !m_empty) m_rd++;
      lvl     = (((wcnt - m_rd) % M) + M) % M;
      m_empty = (lvl == 0);
    end
    e.rptr   = gray(m_rd);
    e.raddr  = A'(m_rd % D);
    e.empty  = m_empty;
    e.aempty = (lvl <= TH);
    e.level  = (A+1)'(lvl);
    e.uf     = m_uf;
    q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge rclk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rptr",       int'(rptr),       int'(e.rptr));
      chk("raddr",      int'(raddr),      int'(e.raddr));
      chk("rempty",     int'(rempty),     int'(e.empty));
      chk("raempty",    int'(raempty),    int'(e.aempty));
      chk("rlevel",     int'(rlevel),     int'(e.level));
      chk("runderflow", int'(runderflow), int'(e.uf));
      chk("rlevel_max", int'(rlevel > (A+1)'(D)), 0);
    end
  end

  initial begin
    // reset with a nonzero write pointer (Gray 00110)
    wcnt = 4;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    // fill to 3 then drain with one extra pop and underflow attempts
    wcnt = 3;
    step(1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    // almost-empty walk from level 5
    wcnt = 5;
    step(1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b1);
    // pop and write in the same cycle at level 1
    wcnt = 6;
    step(1'b1, 1'b0);
    wcnt = 7;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    // wrap: keep the FIFO topped up and pop continuously
    wcnt = m_rd + D;
    step(1'b1, 1'b0);
    repeat (120) begin
      if (wcnt - m_rd < D) wcnt++;
      step(1'b1, 1'b1);
    end
    // randomized traffic with occasional reset
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) begin
        wcnt = $urandom_range(0, D);
        step(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 1) == 1 && wcnt - m_rd < D) wcnt++;
        step(1'b1, $urandom_range(0, 2) != 0);
      end
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge rclk);
    #3;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, meaning FIFO address width (depth 2^ADDRSIZE).
REQ-002 The block SHALL have parameter AEMPTY_THRESH, default 2, meaning the fill level at or below which raempty asserts.
REQ-003 Port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 Port rrst_n  input  1  synchronous, active-low reset, sampled on the rclk rising edge.
REQ-005 Port rinc  input  1  read request; pops one word when rempty=0.
REQ-006 Port rq2_wptr  input  ADDRSIZE+1  write pointer (Gray), already synchronized into rclk.
REQ-007 Port raddr  output  ADDRSIZE  binary read address to the FIFO memory.
REQ-008 Port rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write-domain synchronizer.
REQ-009 Port rempty  output  1  registered FIFO-empty flag.
REQ-010 Port raempty  output  1  registered almost-empty flag.
REQ-011 Port rlevel  output  ADDRSIZE+1  registered fill level, as seen from the read domain.
REQ-012 Port runderflow  output  1  sticky underflow flag.

Function
REQ-013 Internal binary pointer rbin (ADDRSIZE+1 bits); rbinnext = rbin + (rinc AND NOT rempty), modulo 2^(ADDRSIZE+1).
REQ-014 rgraynext = (rbinnext >> 1) XOR rbinnext; rptr <= rgraynext each cycle.
REQ-015 raddr SHALL equal rbin[ADDRSIZE-1:0], taken combinationally from the register, so the memory address changes the same cycle rbin updates.
REQ-016 rempty <= (rgraynext == rq2_wptr); the flag rises in the same edge as the final pop and falls one rclk after rq2_wptr changes.
REQ-017 wbin = Gray-to-binary of rq2_wptr (bit i = XOR of bits ADDRSIZE..i); rlevel <= (wbin - rbinnext) modulo 2^(ADDRSIZE+1).
REQ-018 raempty <= (next rlevel value <= AEMPTY_THRESH); rempty=1 implies raempty=1.
REQ-019 rinc while rempty=1 SHALL NOT change rbin, rptr, raddr or rlevel.
REQ-020 Pointer wrap: rbin rolls from 2^(ADDRSIZE+1)-1 to 0 without a glitch on rptr; exactly one rptr bit changes per pop.
REQ-021 If rinc and a change of rq2_wptr arrive in the same cycle, the block SHALL apply both when computing rempty, rlevel and raempty.
REQ-022 rlevel SHALL never exceed 2^ADDRSIZE when the write side obeys its full flag.

Reset
REQ-023 When rrst_n=0 at an rclk edge: rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
REQ-024 Reset mid-operation SHALL discard any pending pop; the first pop after release requires rempty=0 computed from a post-reset rq2_wptr.
REQ-025 The block SHALL have no asynchronous reset path.

Configuration
REQ-026 Macro RPTR_UNDERFLOW_EN: when defined, runderflow SHALL set on any rclk edge with rinc=1 and rempty=1 and hold until reset.
REQ-027 When RPTR_UNDERFLOW_EN is undefined, runderflow SHALL be tied to 0, the port SHALL remain present, and the block SHALL contain no underflow logic.

Verification
REQ-028 Reset: rrst_n=0 for 2 cycles with rq2_wptr=5'b00110 -> rempty=1, raempty=1, rlevel=0, rptr=0, raddr=0.
REQ-029 Fill/drain: rq2_wptr=Gray(3)=5'b00010, then rinc=1 for 4 cycles -> rempty falls 1 cycle after the wptr change; rlevel follows 3,2,1,0; rempty rises on the 3rd pop; the 4th pop does not move the pointer.
REQ-030 Almost-empty: ADDRSIZE=4, AEMPTY_THRESH=2, rq2_wptr=Gray(5), then pop -> raempty=0 at levels 5,4,3 and raempty=1 at level 2.
REQ-031 Wrap: preload 16 writes repeatedly and pop 40 words -> rptr changes exactly 1 bit per pop; raddr wraps 15 to 0; rbin wraps 31 to 0.
REQ-032 Simultaneous event: level 1, rinc=1 in the same cycle rq2_wptr advances by 1 -> rempty stays 0, rlevel stays 1.
REQ-033 Underflow: with RPTR_UNDERFLOW_EN defined, rinc=1 while rempty=1 -> runderflow=1 from the next edge, held through later valid pops, cleared only by reset; with the macro undefined, runderflow stays 0.
